// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory port between instruction fetch
// (IC) and the load/store buffer (LSB), serialising each request into
// little-endian byte accesses and returning a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop a pending or in-flight IC fetch
//   ic_asking/addr  one-cycle fetch request pulse and its address
//   ic_data/ready   fetched word and its one-cycle done pulse
//   lsb_req/we/size/addr/wdata  level request held until lsb_done
//   lsb_rdata/done  zero-extended load data and one-cycle done pulse
//   mem_din         read byte, returned the cycle after its mem_a
//   mem_dout/a/wr   write byte, byte address, write strobe
module mem_arbiter #(
  parameter int IC_BYTES = 4,
  parameter bit FAIR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ic_asking,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_data,
  output logic        ic_ready,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_rdata,
  output logic        lsb_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [2:0] IC_LEN = 3'(IC_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    RD_IC,
    RD_LSB,
    WR_LSB,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        ic_pending;
  logic [31:0] ic_pend_addr;
  logic        last_ic;
  logic        who_ic;
  logic [31:0] base;
  logic [2:0]  len;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [2:0]  cnt;

  logic        ic_req;
  logic        tie_ic;
  logic        gnt_ic;
  logic        gnt_lsb;
  logic [2:0]  lsb_len;
  logic        rd_st;
  logic        addr_on;
  logic [1:0]  cap_idx;

  // A flush on the grant edge already kills the pending fetch.
  assign ic_req  = ic_pending & ~flush;
  assign tie_ic  = FAIR ? ~last_ic : 1'b0;
  assign gnt_ic  = ic_req & (~lsb_req | tie_ic);
  assign gnt_lsb = lsb_req & ~gnt_ic;

  always_comb begin
    lsb_len = 3'd4;
    unique case (lsb_size)
      2'b00:   lsb_len = 3'd1;
      2'b01:   lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  assign rd_st   = (state == RD_IC) || (state == RD_LSB);
  // Reads spend one extra cycle with no address, catching the last byte.
  assign addr_on = (rd_st && cnt != len) || (state == WR_LSB);
  // Byte presented in cycle k (cnt = k-1) lands when cnt = k.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_ic)
          state_nx = RD_IC;
        else if (gnt_lsb)
          state_nx = lsb_we ? WR_LSB : RD_LSB;
      end
      RD_IC: begin
        if (flush)
          state_nx = IDLE;
        else if (cnt == len)
          state_nx = DONE;
      end
      RD_LSB: begin
        if (cnt == len)
          state_nx = DONE;
      end
      WR_LSB: begin
        if (cnt == len - 3'd1)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_a     = 32'h0;
    mem_wr    = 1'b0;
    mem_dout  = 8'h0;
    ic_ready  = 1'b0;
    ic_data   = 32'h0;
    lsb_done  = 1'b0;
    lsb_rdata = 32'h0;
    if (addr_on)
      mem_a = base + 32'(cnt);
    if (state == WR_LSB) begin
      mem_wr   = 1'b1;
      mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
    end
    if (state == DONE) begin
      if (who_ic) begin
        ic_ready = 1'b1;
        ic_data  = rdata;
      end else begin
        lsb_done  = 1'b1;
        lsb_rdata = rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ic_pending   <= 1'b0;
      ic_pend_addr <= 32'h0;
      last_ic      <= 1'b1;
      who_ic       <= 1'b0;
      base         <= 32'h0;
      len          <= 3'd0;
      wdata        <= 32'h0;
      rdata        <= 32'h0;
      cnt          <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt + 3'd1;

      if (flush)
        ic_pending <= 1'b0;
      if (state == IDLE && gnt_ic)
        ic_pending <= 1'b0;
      // A new pulse wins over flush and grant on the same edge.
      if (ic_asking) begin
        ic_pending   <= 1'b1;
        ic_pend_addr <= ic_addr;
      end

      if (state == IDLE) begin
        cnt   <= 3'd0;
        rdata <= 32'h0;
        if (gnt_ic) begin
          base    <= ic_pend_addr;
          len     <= IC_LEN;
          who_ic  <= 1'b1;
          last_ic <= 1'b1;
        end else if (gnt_lsb) begin
          base    <= lsb_addr;
          len     <= lsb_len;
          wdata   <= lsb_wdata;
          who_ic  <= 1'b0;
          last_ic <= 1'b0;
        end
      end

      if (rd_st && cnt != 3'd0)
        rdata[{cap_idx, 3'b000} +: 8] <= mem_din;
    end
  end

endmodule
